// File: rtl/wb_regfile.sv
// wb_regfile: M/W write-back pipeline, 32x32 byte-masked register file and two forwarded read ports.
// Latency: accepted at edge N, committed at edge N+2; read data/hazard are combinational.
// Backpressure: none internally; hazard asks upstream for bubbles. Build option: WB_FORWARD_EN.
module wb_regfile #(
  parameter int FWD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic        valid_in,
  input  logic [4:0]  wreg_in,
  input  logic [3:0]  wren_in,
  input  logic        is_load_in,
  input  logic [31:0] wdata_in,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        hazard
);

  typedef struct packed {
    logic        vld;
    logic [4:0]  wreg;
    logic [3:0]  wren;
    logic        is_load;
    logic [31:0] dat;
  } m_stage_t;

  // W no longer needs is_load: load data is merged on the way in.
  typedef struct packed {
    logic        vld;
    logic [4:0]  wreg;
    logic [3:0]  wren;
    logic [31:0] dat;
  } w_stage_t;

  m_stage_t    m_q;
  w_stage_t    w_q;
  logic [31:0] regs [32];

  logic                 m_wr;
  logic                 w_wr;
  logic [FWD_DEPTH-1:0] stage_wr;

  logic [1:0][4:0]  ra_v;
  logic [1:0][31:0] rd_v;
  logic [1:0]       haz_v;

  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] dat,
                                              input logic [3:0]  en);
    logic [31:0] res;
    res = base;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) res[8*b +: 8] = dat[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q.vld     <= valid_in;
      m_q.wreg    <= wreg_in;
      m_q.wren    <= wren_in;
      m_q.is_load <= is_load_in;
      m_q.dat     <= wdata_in;
      w_q.vld     <= m_q.vld;
      w_q.wreg    <= m_q.wreg;
      w_q.wren    <= m_q.wren;
      w_q.dat     <= m_q.is_load ? mem_rdata : m_q.dat;
    end
  end

  assign m_wr     = m_q.vld && (m_q.wreg != 5'd0) && (m_q.wren != 4'd0);
  assign w_wr     = w_q.vld && (w_q.wreg != 5'd0) && (w_q.wren != 4'd0);
  assign stage_wr = {w_wr, m_wr};

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (stage_wr[1]) begin
      for (int b = 0; b < 4; b++) begin
        if (w_q.wren[b]) regs[w_q.wreg][8*b +: 8] <= w_q.dat[8*b +: 8];
      end
    end
  end

  assign ra_v = {ra2, ra1};

  // Per port: file value, then older W bytes, then younger M bytes on top.
  always_comb begin
    rd_v  = '0;
    haz_v = '0;
    for (int p = 0; p < 2; p++) begin
      if (ra_v[p] != 5'd0) begin
        rd_v[p] = regs[ra_v[p]];
`ifdef WB_FORWARD_EN
        if (stage_wr[1] && (w_q.wreg == ra_v[p]))
          rd_v[p] = merge_bytes(rd_v[p], w_q.dat, w_q.wren);
        if (stage_wr[0] && !m_q.is_load && (m_q.wreg == ra_v[p]))
          rd_v[p] = merge_bytes(rd_v[p], m_q.dat, m_q.wren);
        haz_v[p] = stage_wr[0] && m_q.is_load && (m_q.wreg == ra_v[p]);
`else
        haz_v[p] = (stage_wr[0] && (m_q.wreg == ra_v[p])) ||
                   (stage_wr[1] && (w_q.wreg == ra_v[p]));
`endif
      end
    end
  end

  assign rd1    = rd_v[0];
  assign rd2    = rd_v[1];
  assign hazard = |haz_v;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: transaction-queue model checked every cycle plus literal expectations.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        valid_in = 1'b0;
  logic [4:0]  wreg_in = '0;
  logic [3:0]  wren_in = '0;
  logic        is_load_in = 1'b0;
  logic [31:0] wdata_in = '0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        hazard;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile #(.FWD_DEPTH(2)) dut (
    .clk(clk), .rstd(rstd), .valid_in(valid_in), .wreg_in(wreg_in),
    .wren_in(wren_in), .is_load_in(is_load_in), .wdata_in(wdata_in),
    .mem_rdata(mem_rdata), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .hazard(hazard)
  );

  typedef struct {
    bit        v;
    bit [4:0]  wreg;
    bit [3:0]  wren;
    bit        ld;
    bit [31:0] data;
  } ent_t;

  // q[0] = youngest in-flight instruction, q[1] = oldest (next to commit).
  ent_t      q[$];
  bit [31:0] mreg [32];

  function automatic bit writer(input ent_t e);
    return e.v && (e.wreg != 0) && (e.wren != 0);
  endfunction

  task automatic model_reset();
    ent_t nop;
    nop = '{v: 0, wreg: 0, wren: 0, ld: 0, data: 0};
    for (int i = 0; i < 32; i++) mreg[i] = 0;
    q.delete();
    q.push_back(nop);
    q.push_back(nop);
  endtask

  task automatic model_edge();
    ent_t old;
    ent_t yng;
    ent_t n;
    old = q.pop_back();
    if (writer(old))
      for (int b = 0; b < 4; b++)
        if (old.wren[b]) mreg[old.wreg][8*b +: 8] = old.data[8*b +: 8];
    yng = q[0];
    if (yng.ld) yng.data = mem_rdata;
    q[0] = yng;
    n = '{v: valid_in, wreg: wreg_in, wren: wren_in, ld: is_load_in, data: wdata_in};
    q.push_front(n);
  endtask

  task automatic predict(input bit [4:0] ra, output bit [31:0] rd, output bit hz);
    rd = 0;
    hz = 0;
    if (ra != 0) begin
      rd = mreg[ra];
      for (int s = 1; s >= 0; s--) begin
        if (writer(q[s]) && q[s].wreg == ra) begin
`ifdef WB_FORWARD_EN
          if (s == 0 && q[s].ld) hz = 1;
          else
            for (int b = 0; b < 4; b++)
              if (q[s].wren[b]) rd[8*b +: 8] = q[s].data[8*b +: 8];
`else
          hz = 1;
`endif
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstd);
      if (!rstd) model_reset();
      else model_edge();
    end
  end

  initial begin
    bit [31:0] e1, e2;
    bit        h1, h2;
    forever begin
      @(negedge clk);
      predict(ra1, e1, h1);
      predict(ra2, e2, h2);
      chk("model_rd1", rd1, e1);
      chk("model_rd2", rd2, e2);
      chk("model_hazard", {31'b0, hazard}, {31'b0, h1 | h2});
    end
  end

  task automatic set_in(input bit v, input bit [4:0] w, input bit [3:0] en,
                        input bit ld, input bit [31:0] d);
    valid_in = v; wreg_in = w; wren_in = en; is_load_in = ld; wdata_in = d;
  endtask

  task automatic bubble();
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ra1 = 5; ra2 = 7;
    tick(); tick();
    @(negedge clk);
    chk("reset_rd1", rd1, 0);
    chk("reset_rd2", rd2, 0);
    chk("reset_hazard", hazard, 0);
    tick();
    rstd = 1'b1;
    tick();

    // Back-to-back ALU result
    ra1 = 5; ra2 = 0;
    set_in(1, 5, 4'hF, 0, 32'h12345678);
    tick(); bubble();
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("alu_fwd_m", rd1, 32'h12345678);
`else
    chk("alu_haz_m", hazard, 1);
`endif
    tick();
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("alu_fwd_w", rd1, 32'h12345678);
`else
    chk("alu_haz_w", hazard, 1);
`endif
    tick();
    @(negedge clk);
    chk("alu_commit", rd1, 32'h12345678);
    chk("alu_commit_haz", hazard, 0);

    // Load-use
    ra1 = 0; ra2 = 7;
    set_in(1, 7, 4'hF, 1, 32'h0BAD0BAD);
    tick(); bubble();
    mem_rdata = 32'hCAFEBABE;
    @(negedge clk);
    chk("ld_haz_m", hazard, 1);
    tick();
    mem_rdata = 32'h0;
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("ld_fwd_w", rd2, 32'hCAFEBABE);
    chk("ld_haz_w", hazard, 0);
`else
    chk("ld_haz_w", hazard, 1);
`endif
    tick();
    @(negedge clk);
    chk("ld_commit", rd2, 32'hCAFEBABE);
    chk("ld_commit_haz", hazard, 0);

    // Byte lanes, overlapping enables in M and W
    ra2 = 0;
    set_in(1, 9, 4'hF, 0, 32'hAAAAAAAA);
    tick(); bubble(); tick(); tick();
    set_in(1, 9, 4'b1100, 0, 32'h11223344);
    tick();
    set_in(1, 9, 4'b1110, 0, 32'h55667788);
    tick(); bubble();
    ra1 = 9;
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("bytes_mw", rd1, 32'h556677AA);
`else
    chk("bytes_haz_mw", hazard, 1);
`endif
    tick();
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("bytes_w", rd1, 32'h556677AA);
`else
    chk("bytes_stale_w", rd1, 32'h1122AAAA);
`endif
    tick();
    @(negedge clk);
    chk("bytes_commit", rd1, 32'h556677AA);

    // Disjoint enables in M and W combine with the file
    ra1 = 0;
    set_in(1, 20, 4'hF, 0, 32'h01020304);
    tick(); bubble(); tick(); tick();
    set_in(1, 20, 4'b0001, 0, 32'h000000AA);
    tick();
    set_in(1, 20, 4'b1000, 0, 32'hBB000000);
    tick(); bubble();
    ra1 = 20;
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("disjoint_mw", rd1, 32'hBB0203AA);
`else
    chk("disjoint_stale", rd1, 32'h01020304);
`endif
    tick(); tick();
    @(negedge clk);
    chk("disjoint_commit", rd1, 32'hBB0203AA);

    // No-write cases
    ra1 = 0; ra2 = 3;
    set_in(1, 0, 4'hF, 0, 32'hFFFFFFFF);
    tick();
    set_in(1, 3, 4'b0000, 1, 32'hDEADBEEF);
    tick(); bubble();
    @(negedge clk);
    chk("nowr_r3", rd2, 0);
    chk("nowr_r0", rd1, 0);
    chk("nowr_haz", hazard, 0);
    tick(); tick();
    @(negedge clk);
    chk("nowr_r3_after", rd2, 0);

    // Dual port read of the same register during its commit
    ra1 = 0; ra2 = 0;
    set_in(1, 12, 4'hF, 0, 32'h0000BEEF);
    tick(); bubble(); tick();
    ra1 = 12; ra2 = 12;
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("dual_rd1_commit", rd1, 32'h0000BEEF);
    chk("dual_rd2_commit", rd2, 32'h0000BEEF);
`else
    chk("dual_haz_commit", hazard, 1);
`endif
    tick();
    @(negedge clk);
    chk("dual_rd1_after", rd1, 32'h0000BEEF);
    chk("dual_rd2_after", rd2, 32'h0000BEEF);

    // Reset with M and W both holding writers
    ra1 = 5; ra2 = 12;
    set_in(1, 5, 4'hF, 0, 32'h99999999);
    tick();
    set_in(1, 12, 4'hF, 0, 32'h77777777);
    tick(); bubble();
    rstd = 1'b0;
    #1;
    chk("rst_mid_rd1", rd1, 0);
    chk("rst_mid_rd2", rd2, 0);
    chk("rst_mid_haz", hazard, 0);
    tick();
    rstd = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_r5", rd1, 0);
    chk("rst_r12", rd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
